framebuffer_scanout: RTL

- Read-side counterpart to the FrameBuffer write/clear path.
- Generates 640x480@60 VGA timing from the 100 MHz system clock.
- Issues one framebuffer read per active pixel and drives 4-bit-per-channel RGB with hsync and vsync.
- Forwards renderer clear requests to FrameBuffer.clearBuffer, but only at the start of vertical blanking, so a visible frame is never torn by a clear.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_gen.sv | 94 +++++++++
 rtl/framebuffer_scanout.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter widths and the RGB444 pixel type
// used by the scanout path.
package vga_timing_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int V_ACTIVE     = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int CLK_DIV      = 4;
    localparam int READ_LATENCY = 1;
    localparam int COLOR_DEPTH  = 4;

    localparam int H_CNT_W = 10;
    localparam int V_CNT_W = 10;
    localparam int COORD_W = 13;

    typedef struct packed {
        logic [COLOR_DEPTH-1:0] r;
        logic [COLOR_DEPTH-1:0] g;
        logic [COLOR_DEPTH-1:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider plus horizontal/vertical raster counters, with active,
// sync-window and blanking decode and the frame/vblank start pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FPORCH  = 16,
    parameter int H_PULSE   = 96,
    parameter int H_BPORCH  = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FPORCH  = 10,
    parameter int V_PULSE   = 2,
    parameter int V_BPORCH  = 33,
    parameter int DIVIDE    = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               tick,
    output logic [H_CNT_W-1:0] h_count,
    output logic [V_CNT_W-1:0] v_count,
    output logic               active,
    output logic               hsync_window,
    output logic               vsync_window,
    output logic               vblank,
    output logic               frame_start,
    output logic               vblank_start
);

    localparam int H_LAST   = H_VISIBLE + H_FPORCH + H_PULSE + H_BPORCH - 1;
    localparam int V_LAST   = V_VISIBLE + V_FPORCH + V_PULSE + V_BPORCH - 1;
    localparam int HS_FIRST = H_VISIBLE + H_FPORCH;
    localparam int HS_LAST  = HS_FIRST + H_PULSE - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FPORCH;
    localparam int VS_LAST  = VS_FIRST + V_PULSE - 1;
    localparam int DIV_W    = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

    logic [DIV_W-1:0]   div_count_reg;
    logic [H_CNT_W-1:0] h_count_reg;
    logic [H_CNT_W-1:0] h_next;
    logic [V_CNT_W-1:0] v_count_reg;
    logic [V_CNT_W-1:0] v_next;
    logic               running_reg;
    logic               frame_start_reg;
    logic               vblank_start_reg;

    assign tick = (div_count_reg == DIV_W'(DIVIDE - 1));

    // The first tick after reset enters pixel (0,0) instead of stepping past it,
    // so the opening pixel of the first frame is still fetched and displayed.
    always_comb begin
        h_next = h_count_reg;
        v_next = v_count_reg;
        if (running_reg) begin
            if (h_count_reg == H_CNT_W'(H_LAST)) begin
                h_next = '0;
                v_next = (v_count_reg == V_CNT_W'(V_LAST)) ? '0 : v_count_reg + V_CNT_W'(1);
            end else begin
                h_next = h_count_reg + H_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_count_reg    <= '0;
            h_count_reg      <= '0;
            v_count_reg      <= '0;
            running_reg      <= 1'b0;
            frame_start_reg  <= 1'b0;
            vblank_start_reg <= 1'b0;
        end else begin
            div_count_reg    <= tick ? '0 : div_count_reg + DIV_W'(1);
            frame_start_reg  <= 1'b0;
            vblank_start_reg <= 1'b0;
            if (tick) begin
                running_reg      <= 1'b1;
                h_count_reg      <= h_next;
                v_count_reg      <= v_next;
                frame_start_reg  <= (h_next == '0) && (v_next == '0);
                vblank_start_reg <= (h_next == '0) && (v_next == V_CNT_W'(V_VISIBLE));
            end
        end
    end

    assign h_count      = h_count_reg;
    assign v_count      = v_count_reg;
    assign active       = (h_count_reg < H_CNT_W'(H_VISIBLE)) && (v_count_reg < V_CNT_W'(V_VISIBLE));
    assign hsync_window = (h_count_reg >= H_CNT_W'(HS_FIRST)) && (h_count_reg <= H_CNT_W'(HS_LAST));
    assign vsync_window = (v_count_reg >= V_CNT_W'(VS_FIRST)) && (v_count_reg <= V_CNT_W'(VS_LAST));
    assign vblank       = (v_count_reg >= V_CNT_W'(V_VISIBLE));
    assign frame_start  = frame_start_reg;
    assign vblank_start = vblank_start_reg;

endmodule

// File: rtl/framebuffer_scanout.sv
// Read side of the framebuffer: fetches one word per visible pixel, drives
// VGA colour and syncs one pixel behind the counters, and defers clears to vblank.
module framebuffer_scanout
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = 640,
    parameter int H_FPORCH   = 16,
    parameter int H_PULSE    = 96,
    parameter int H_BPORCH   = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FPORCH   = 10,
    parameter int V_PULSE    = 2,
    parameter int V_BPORCH   = 33,
    parameter int DIVIDE     = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     readEnable,
    output logic [COORD_W-1:0]       readX,
    output logic [COORD_W-1:0]       readY,
    input  logic [3*COLOR_DEPTH-1:0] readVal,
    input  logic                     clearRequest,
    output logic                     clearBuffer,
    output logic [COLOR_DEPTH-1:0]   red,
    output logic [COLOR_DEPTH-1:0]   green,
    output logic [COLOR_DEPTH-1:0]   blue,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     vblank,
    output logic                     frameStart
);

    logic               tick;
    logic [H_CNT_W-1:0] h_count;
    logic [V_CNT_W-1:0] v_count;
    logic               active;
    logic               hsync_window;
    logic               vsync_window;
    logic               vblank_start;
    logic               pixel_start_reg;
    logic               clear_pending_reg;
    rgb444_t            pixel_reg;
    logic               pending_reg [RD_LATENCY];

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FPORCH  (H_FPORCH),
        .H_PULSE   (H_PULSE),
        .H_BPORCH  (H_BPORCH),
        .V_VISIBLE (V_VISIBLE),
        .V_FPORCH  (V_FPORCH),
        .V_PULSE   (V_PULSE),
        .V_BPORCH  (V_BPORCH),
        .DIVIDE    (DIVIDE)
    ) u_timing (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .h_count      (h_count),
        .v_count      (v_count),
        .active       (active),
        .hsync_window (hsync_window),
        .vsync_window (vsync_window),
        .vblank       (vblank),
        .frame_start  (frameStart),
        .vblank_start (vblank_start)
    );

    // Tracks the outstanding read so readVal is only sampled when it belongs to us.
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pending
        if (gi == 0) begin : g_first
            always_ff @(posedge clock or posedge reset) begin
                if (reset) pending_reg[gi] <= 1'b0;
                else       pending_reg[gi] <= readEnable;
            end
        end else begin : g_rest
            always_ff @(posedge clock or posedge reset) begin
                if (reset) pending_reg[gi] <= 1'b0;
                else       pending_reg[gi] <= pending_reg[gi-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_start_reg   <= 1'b0;
            readEnable        <= 1'b0;
            readX             <= '0;
            readY             <= '0;
            pixel_reg         <= '0;
            red               <= '0;
            green             <= '0;
            blue              <= '0;
            hsync             <= 1'b1;
            vsync             <= 1'b1;
            clearBuffer       <= 1'b0;
            clear_pending_reg <= 1'b0;
        end else begin
            pixel_start_reg <= tick;
            readEnable      <= pixel_start_reg && active;
            if (pixel_start_reg && active) begin
                readX <= COORD_W'(h_count);
                readY <= COORD_W'(v_count);
            end
            if (pending_reg[RD_LATENCY-1]) begin
                pixel_reg <= rgb444_t'(readVal);
            end
            // Counters still hold the pixel whose period ends here, so colour
            // and syncs come out together exactly one pixel behind them.
            if (tick) begin
                red   <= active ? pixel_reg.r : '0;
                green <= active ? pixel_reg.g : '0;
                blue  <= active ? pixel_reg.b : '0;
                hsync <= ~hsync_window;
                vsync <= ~vsync_window;
            end
            clearBuffer       <= vblank_start && clear_pending_reg;
            clear_pending_reg <= clearRequest || (clear_pending_reg && !vblank_start);
        end
    end

endmodule
